// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared ALU op codes, op legality check and controller FSM states.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Purpose : combinational ALU (AND/OR/ADD/SUB/unsigned SLT) with zero flag.
// Latency : 0 cycles, purely combinational.
// Backpressure: none; caller owns sequencing.
// Ports: a, b operands; alu_control op code; result, zero outputs.
module alu_share_ctrl_alu
   import alu_ctrl_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   alu_control,
   output logic [W-1:0] result,
   output logic         zero
);

   always_comb begin
      result = '0;
      case (alu_control)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_SLT:  result = {{(W-1){1'b0}}, (a < b)};
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_share_ctrl_arb.sv
// Purpose : 2-way grant, round-robin via ptr or fixed priority to requester 0.
// Latency : 0 cycles, purely combinational.
// Backpressure: a lone requester always wins; gnt is one-hot or zero.
// Ports: req request vector, ptr preferred requester on conflict, fixed forces 0; gnt grant.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       fixed,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (fixed || !ptr) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Purpose : time-shares one ALU between two requesters, returns result to the winner.
// Latency : accept in cycle N -> resp_valid in N+2; at most one op per 3 cycles.
// Backpressure: req_ready only in IDLE; response held until resp_ready of the winner.
// Ports: req_* per-requester op channel, resp_* per-requester valid with shared
//        result/zero/err bus, busy = controller not idle.
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   input  logic [7:0]          req_op,
   output logic [1:0]          resp_valid,
   input  logic [1:0]          resp_ready,
   output logic [DATA_W-1:0]   resp_result,
   output logic                resp_zero,
   output logic                resp_err,
   output logic                busy
);

   state_t            state, state_nxt;
   logic              rr_ptr;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic [3:0]        sel_op;

   logic [DATA_W-1:0] a_q, b_q, res_q;
   logic [3:0]        op_q;
   logic              id_q, err_q, zero_q;

   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   arb_rr2 u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .fixed (PRIO_FIXED),
      .gnt   (gnt)
   );

   assign gnt_id = gnt[1];
   assign sel_a  = gnt_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
   assign sel_b  = gnt_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
   assign sel_op = gnt_id ? req_op[7:4] : req_op[3:0];

   // Illegal codes are replaced by AND at capture so the ALU never sees them.
   assign alu_op = op_q;

   alu_share_ctrl_alu #(.W(DATA_W)) u_alu (
      .a           (a_q),
      .b           (b_q),
      .alu_control (alu_op),
      .result      (alu_result),
      .zero        (alu_zero)
   );

   always_comb begin
      state_nxt  = state;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      case (state)
         ST_IDLE: begin
            req_ready = gnt;
            if (gnt != 2'b00) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            resp_valid[id_q] = 1'b1;
            if (resp_ready[id_q]) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         rr_ptr <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_AND;
         id_q   <= 1'b0;
         err_q  <= 1'b0;
         res_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && gnt != 2'b00) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            op_q  <= op_legal(sel_op) ? sel_op : OP_AND;
            id_q  <= gnt_id;
            err_q <= !op_legal(sel_op);
         end
         if (state == ST_EXEC) begin
            // An illegal op still ran AND on real operands; force the documented 0 result.
            res_q  <= err_q ? '0 : alu_result;
            zero_q <= err_q | alu_zero;
         end
         if (state == ST_RESP && resp_ready[id_q] && !PRIO_FIXED) begin
            rr_ptr <= ~id_q;
         end
      end
   end

   assign resp_result = res_q;
   assign resp_zero   = zero_q;
   assign resp_err    = err_q;
   assign busy        = (state != ST_IDLE);

endmodule
